// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage. Holds the architectural PC (word address [31:2]),
//   fetches one instruction at a time from instruction memory over a
//   req/gnt/rvalid handshake and hands it to decode with valid/ready. The PC
//   is reloaded from npc only when decode accepts the held instruction. A
//   WAIT-timeout counter flags a hung memory and parks the stage until reset.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   npc          next PC[31:2] from the npc block
//   pc           current PC[31:2]
//   imem_req     fetch request, held until imem_gnt
//   imem_addr    fetch word address (= pc)
//   imem_gnt     memory accepted the request this cycle
//   imem_rvalid  imem_rdata valid (only honoured in WAIT)
//   imem_rdata   fetched instruction word
//   inst         instruction to decode
//   inst_valid   inst valid
//   dec_ready    decode accepts inst this cycle
//   fetch_err    sticky timeout flag
//
// State | meaning
//   BOOT  | one idle cycle after reset release
//   REQ   | imem_req asserted, waiting for imem_gnt
//   WAIT  | request granted, waiting for imem_rvalid (timed)
//   HOLD  | instruction presented to decode, waiting for dec_ready
//   FAULT | memory timed out; parked until reset
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [29:0] RESET_PC     = 30'h0C00,
  parameter int          WAIT_TIMEOUT = 16,
  parameter int          CNT_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] npc,
  output logic [29:0] pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        dec_ready,
  output logic        fetch_err
);

  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Down-counter loaded on grant; reaching zero without rvalid is the
  // WAIT_TIMEOUT-th cycle spent in WAIT.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [29:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        // rvalid on the expiry cycle takes priority over the fault
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = ST_HOLD;
        end else if (cnt_q == '0) begin
          fetch_err_d = 1'b1;
          state_d     = ST_FAULT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (dec_ready) begin
          pc_d    = npc;
          state_d = ST_REQ;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0;
      fetch_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs come only from registers or state decode: no input-to-output path.
  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == ST_REQ);
  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_q;
  assign fetch_err  = fetch_err_q;

endmodule
